// File: rtl/cpu_multicycle.sv
// Multi-cycle 16-bit-instruction CPU with valid/request fetch handshake and parametrised register file.
// Optional retirement counter port enabled by defining CPU_RETIRE_CNT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------
// FETCH     | request instruction at pc, wait for instr_valid
// DECODE    | latch operands from register file, flag illegal ops
// EXECUTE   | compute alu_result
// WRITEBACK | register write, pc update
// HALT      | stopped until reset
module cpu_multicycle #(
    parameter int DATA_W    = 8,
    parameter int REG_COUNT = 4,
    parameter int PC_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic              instr_req,
    output logic [PC_W-1:0]   instr_addr,
    input  logic              instr_valid,
    input  logic [15:0]       instr_data,
    output logic [PC_W-1:0]   pc_out,
    output logic [15:0]       instr,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] alu_result,
    output logic              halted,
`ifdef CPU_RETIRE_CNT_EN
    output logic [15:0]       retire_count,
`endif
    output logic              illegal
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LI   = 4'h6;
    localparam logic [3:0] OP_BNZ  = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [15:0]         instr_q, instr_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [DATA_W-1:0]   alu_q, alu_d;
    logic                illegal_q, illegal_d;
    logic [DATA_W-1:0]   rf_q [REG_COUNT];
    logic [DATA_W-1:0]   rf_d [REG_COUNT];

    logic [3:0]          op, rd, rs, rt;
    logic [7:0]          imm8;
    logic [DATA_W-1:0]   imm_ext;
    logic [PC_W-1:0]     target;
    logic [DATA_W-1:0]   rd_val, rs_val, rt_val;
    logic                op_legal;
    logic                rf_we;

    assign op   = instr_q[15:12];
    assign rd   = instr_q[11:8];
    assign rs   = instr_q[7:4];
    assign rt   = instr_q[3:0];
    assign imm8 = instr_q[7:0];

    always_comb begin
        imm_ext      = '0;
        imm_ext[7:0] = imm8;
        target       = '0;
        target[7:0]  = imm8;
    end

    // Register reads by compare so indices beyond REG_COUNT fall through to 0.
    always_comb begin
        rd_val = '0;
        rs_val = '0;
        rt_val = '0;
        for (int i = 0; i < REG_COUNT; i++) begin
            if (rd == i[3:0]) rd_val = rf_q[i];
            if (rs == i[3:0]) rs_val = rf_q[i];
            if (rt == i[3:0]) rt_val = rf_q[i];
        end
    end

    always_comb begin
        case (op)
            OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LI,
            OP_BNZ, OP_JMP, OP_HALT: op_legal = 1'b1;
            default:                 op_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        illegal_d = illegal_q;
        rf_we     = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    instr_d = instr_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d = (op == OP_BNZ) ? rd_val : rs_val;
                b_d = rt_val;
                if (!op_legal) illegal_d = 1'b1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                case (op)
                    OP_ADD:         alu_d = a_q + b_q;
                    OP_SUB:         alu_d = a_q - b_q;
                    OP_AND:         alu_d = a_q & b_q;
                    OP_OR:          alu_d = a_q | b_q;
                    OP_XOR:         alu_d = a_q ^ b_q;
                    OP_LI:          alu_d = imm_ext;
                    OP_BNZ, OP_JMP: alu_d = imm_ext;
                    default:        alu_d = alu_q;
                endcase
                state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                rf_we = (op >= OP_ADD) && (op <= OP_LI);
                pc_d  = pc_q + PC_W'(1);
                if (op == OP_JMP) pc_d = target;
                if ((op == OP_BNZ) && (a_q != '0)) pc_d = target;
                state_d = (op == OP_HALT) ? S_HALT : S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    // Writes to indices beyond REG_COUNT match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < REG_COUNT; i++) begin
            rf_d[i] = (rf_we && (rd == i[3:0])) ? alu_q : rf_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= '0;
            instr_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            illegal_q <= 1'b0;
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instr_q   <= instr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= rf_d[i];
        end
    end

`ifdef CPU_RETIRE_CNT_EN
    logic [15:0] retire_q, retire_d;

    always_comb begin
        retire_d = retire_q;
        if (state_q == S_WRITEBACK) retire_d = retire_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) retire_q <= '0;
        else       retire_q <= retire_d;
    end

    assign retire_count = retire_q;
`endif

    assign instr_req  = (state_q == S_FETCH) && !reset;
    assign instr_addr = pc_q;
    assign pc_out     = pc_q;
    assign instr      = instr_q;
    assign reg_a      = a_q;
    assign reg_b      = b_q;
    assign alu_result = alu_q;
    assign halted     = (state_q == S_HALT);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: small programs in a behavioural instruction memory
// with configurable fetch wait, checked against hand-computed values.
module tb_cpu_multicycle;
    localparam int DATA_W    = 8;
    localparam int REG_COUNT = 4;
    localparam int PC_W      = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              instr_req;
    logic [PC_W-1:0]   instr_addr;
    logic              instr_valid;
    logic [15:0]       instr_data;
    logic [PC_W-1:0]   pc_out;
    logic [15:0]       instr;
    logic [DATA_W-1:0] reg_a, reg_b, alu_result;
    logic              halted, illegal;
`ifdef CPU_RETIRE_CNT_EN
    logic [15:0]       retire_count;
`endif

    logic [15:0] mem [256];
    logic        force_valid = 1'b0;
    int          wait_pc     = -1;
    int          wait_cycles = 0;
    int          wait_cnt    = 0;
    int          n_vec       = 0;
    int          n_miss      = 0;

    always #5 clk = ~clk;

    cpu_multicycle #(.DATA_W(DATA_W), .REG_COUNT(REG_COUNT), .PC_W(PC_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_req   (instr_req),
        .instr_addr  (instr_addr),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .pc_out      (pc_out),
        .instr       (instr),
        .reg_a       (reg_a),
        .reg_b       (reg_b),
        .alu_result  (alu_result),
        .halted      (halted),
`ifdef CPU_RETIRE_CNT_EN
        .retire_count(retire_count),
`endif
        .illegal     (illegal)
    );

    assign instr_data  = mem[instr_addr];
    assign instr_valid = force_valid |
                         (instr_req && ((int'(instr_addr) == wait_pc) ? (wait_cnt >= wait_cycles) : 1'b1));

    always @(posedge clk) begin
        if (reset || !instr_req || instr_valid) wait_cnt <= 0;
        else                                    wait_cnt <= wait_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hF000;
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // Program A: arithmetic, dropped write probe, SUB wrap; valid held high everywhere.
        clear_mem();
        mem[0] = 16'h6105;   // LI  R1,0x05
        mem[1] = 16'h6203;   // LI  R2,0x03
        mem[2] = 16'h1312;   // ADD R3,R1,R2
        mem[3] = 16'h4F30;   // OR  R15,R3,R0 (write dropped)
        mem[4] = 16'h2021;   // SUB R0,R2,R1
        mem[5] = 16'hF000;   // HALT
        force_valid = 1'b1;
        do_reset();
        #1;
        chk("rst_pc",      32'(pc_out), 0);
        chk("rst_instr",   32'(instr), 0);
        chk("rst_alu",     32'(alu_result), 0);
        chk("rst_halted",  32'(halted), 0);
        chk("rst_req",     32'(instr_req), 1);
        cycles(4);
        chk("a_li1_pc",    32'(pc_out), 1);
        chk("a_li1_alu",   32'(alu_result), 32'h05);
        cycles(8);
        chk("a_add_pc",    32'(pc_out), 3);
        chk("a_add_alu",   32'(alu_result), 32'h08);
        chk("a_add_rega",  32'(reg_a), 32'h05);
        chk("a_add_regb",  32'(reg_b), 32'h03);
        chk("a_add_instr", 32'(instr), 32'h1312);
        cycles(4);
        chk("a_probe_r3",  32'(reg_a), 32'h08);
        chk("a_probe_alu", 32'(alu_result), 32'h08);
        cycles(4);
        chk("a_sub_wrap",  32'(alu_result), 32'hFE);
        chk("a_sub_pc",    32'(pc_out), 5);
        cycles(3);
        chk("a_pre_halt",  32'(halted), 0);
        cycles(1);
        chk("a_halted",    32'(halted), 1);
        chk("a_halt_req",  32'(instr_req), 0);
        cycles(5);
        chk("a_halt_hold", 32'(halted), 1);
        chk("a_halt_ins",  32'(instr), 32'hF000);
        chk("a_halt_alu",  32'(alu_result), 32'hFE);
        force_valid = 1'b0;

        // Program B: 3 wait cycles on the fetch at pc = 2.
        clear_mem();
        mem[0] = 16'h6105;
        mem[1] = 16'h6203;
        mem[2] = 16'h1312;   // ADD R3,R1,R2
        mem[3] = 16'h4F33;   // OR  R15,R3,R3
        wait_pc     = 2;
        wait_cycles = 3;
        do_reset();
        cycles(8);
        for (int k = 0; k < 3; k++) begin
            cycles(1);
            chk("b_wait_req",  32'(instr_req), 1);
            chk("b_wait_addr", 32'(instr_addr), 2);
            chk("b_wait_ins",  32'(instr), 32'h6203);
        end
        cycles(3);
        chk("b_mid_pc",    32'(pc_out), 2);
        cycles(1);
        chk("b_add_pc",    32'(pc_out), 3);
        chk("b_add_alu",   32'(alu_result), 32'h08);
        cycles(4);
        chk("b_probe_pc",  32'(pc_out), 4);
        chk("b_probe_a",   32'(reg_a), 32'h08);
        chk("b_probe_b",   32'(reg_b), 32'h08);
        wait_pc = -1;

        // Program C: countdown loop with BNZ taken twice.
        clear_mem();
        mem[0] = 16'h6201;   // LI  R2,1
        mem[1] = 16'h6103;   // LI  R1,3
        mem[2] = 16'h2112;   // SUB R1,R1,R2
        mem[3] = 16'h8102;   // BNZ R1,->2
        mem[4] = 16'hF000;   // HALT
        do_reset();
        cycles(16);
        chk("c_bnz1_pc",   32'(pc_out), 2);
        chk("c_bnz1_a",    32'(reg_a), 2);
        cycles(8);
        chk("c_bnz2_pc",   32'(pc_out), 2);
        chk("c_bnz2_a",    32'(reg_a), 1);
        cycles(4);
        chk("c_sub3_alu",  32'(alu_result), 0);
        cycles(4);
        chk("c_bnz3_pc",   32'(pc_out), 4);
        chk("c_bnz3_a",    32'(reg_a), 0);
        cycles(4);
        chk("c_halted",    32'(halted), 1);
        chk("c_halt_req",  32'(instr_req), 0);
`ifdef CPU_RETIRE_CNT_EN
        chk("c_retire",    32'(retire_count), 9);
`endif
        force_valid = 1'b1;
        cycles(4);
        chk("c_hold_halt", 32'(halted), 1);
        chk("c_hold_ins",  32'(instr), 32'hF000);
        force_valid = 1'b0;

        // Program D: illegal opcode 0x7, then ADD; reset dropped in during EXECUTE.
        clear_mem();
        mem[0] = 16'h6105;
        mem[1] = 16'h6203;
        mem[2] = 16'h7112;   // illegal, rd = R1
        mem[3] = 16'h1312;   // ADD R3,R1,R2
        mem[4] = 16'hF000;
        do_reset();
        cycles(9);
        chk("d_ill_pre",   32'(illegal), 0);
        cycles(1);
        chk("d_ill_set",   32'(illegal), 1);
        cycles(2);
        chk("d_ill_pc",    32'(pc_out), 3);
        chk("d_ill_alu",   32'(alu_result), 32'h03);
        cycles(2);
        chk("d_add_a",     32'(reg_a), 32'h05);
        cycles(2);
        chk("d_add_alu",   32'(alu_result), 32'h08);
        chk("d_ill_stick", 32'(illegal), 1);
        cycles(2);
        @(negedge clk) reset = 1'b1;
        @(posedge clk) #1;
        chk("d_rst_pc",    32'(pc_out), 0);
        chk("d_rst_ins",   32'(instr), 0);
        chk("d_rst_a",     32'(reg_a), 0);
        chk("d_rst_b",     32'(reg_b), 0);
        chk("d_rst_alu",   32'(alu_result), 0);
        chk("d_rst_ill",   32'(illegal), 0);
        chk("d_rst_hlt",   32'(halted), 0);
        chk("d_rst_req",   32'(instr_req), 0);
        @(negedge clk) reset = 1'b0;
        #1;
        chk("d_rel_req",   32'(instr_req), 1);
        chk("d_rel_addr",  32'(instr_addr), 0);
        cycles(4);
        chk("d_rel_pc",    32'(pc_out), 1);
        chk("d_rel_ins",   32'(instr), 32'h6105);
        chk("d_rel_ill",   32'(illegal), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got 0x1 expected 0x0");
        $fatal(1, "bench timeout");
    end
endmodule
